ped_signal_controller: RTL and testbench

PED_SIGNAL_CONTROLLER -- requirements
Module: ped_signal_controller

---
 rtl/ped_signal_controller.sv | 152 +++++++++++++++
 tb/tb_ped_signal_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ped_signal_controller.sv
// ped_signal_controller
// Pedestrian crossing controller that follows an upstream vehicle light.
// A button press is latched as a pending request. It is served on the next
// rising edge of the vehicle red light. The crossing runs a steady WALK phase
// followed by a flashing don't-walk phase. If red drops mid-crossing, the
// crossing is aborted. An illegal vehicle-light combination latches FAULT
// until reset.
//
// Configuration macro: PED_COUNTDOWN_EN
//   defined   -> countdown shows the remaining flash cycles
//   undefined -> countdown is tied to zero and the counter is not built
//
// Ports
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous, active-high reset
//   red, yellow, green  in   vehicle light state
//   ped_button          in   pedestrian request (level)
//   walk                out  walk lamp
//   dont_walk           out  don't-walk lamp
//   ped_wait            out  request pending
//   countdown[3:0]      out  remaining flash cycles
//   fault               out  illegal light combination latched
//
// state | meaning
// IDLE  | don't-walk steady, waiting for a request and a red rise
// WALK  | walk lamp on for WALK_CYCLES cycles
// FLASH | don't-walk toggling for FLASH_CYCLES cycles
// FAULT | illegal vehicle lights seen, held until reset
module ped_signal_controller #(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       ped_button,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_wait,
  output logic [3:0] countdown,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, WALK, FLASH, FAULT} state_t;

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] timer, timer_n;
  logic       red_q, btn_q;
  logic       ped_wait_n, walk_n, dont_walk_n, fault_n;
  logic       illegal, red_rise, btn_rise;

  assign illegal  = (red & yellow) | (red & green) | (yellow & green);
  assign red_rise = red & ~red_q;
  assign btn_rise = ped_button & ~btn_q;

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    ped_wait_n = ped_wait;
    if (btn_rise) ped_wait_n = 1'b1;

    if (illegal) begin
      state_n = FAULT;
    end else begin
      case (state)
        IDLE: begin
          // A press in the same cycle as the red rise is served immediately.
          if (red_rise && (ped_wait || btn_rise)) begin
            state_n = WALK;
            timer_n = WALK_LOAD;
          end
        end
        WALK: begin
          if (!red) begin
            state_n = IDLE;
            timer_n = 8'd0;
          end else if (timer == 8'd0) begin
            state_n = FLASH;
            timer_n = FLASH_LOAD;
          end else begin
            timer_n = timer - 8'd1;
          end
        end
        FLASH: begin
          if (!red || timer == 8'd0) begin
            state_n = IDLE;
            timer_n = 8'd0;
          end else begin
            timer_n = timer - 8'd1;
          end
        end
        default: state_n = FAULT;
      endcase
    end

    if ((state_n == WALK && state != WALK) || state_n == FAULT)
      ped_wait_n = 1'b0;

    walk_n  = (state_n == WALK);
    fault_n = (state_n == FAULT);
    case (state_n)
      WALK:    dont_walk_n = 1'b0;
      FLASH:   dont_walk_n = (state == FLASH) ? ~dont_walk : 1'b1;
      default: dont_walk_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= 8'd0;
      red_q     <= 1'b0;
      btn_q     <= 1'b0;
      ped_wait  <= 1'b0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      red_q     <= red;
      btn_q     <= ped_button;
      ped_wait  <= ped_wait_n;
      walk      <= walk_n;
      dont_walk <= dont_walk_n;
      fault     <= fault_n;
    end
  end

`ifdef PED_COUNTDOWN_EN
  logic [3:0] countdown_n;

  always_comb begin
    countdown_n = 4'd0;
    if (state_n == FLASH)
      countdown_n = (state == FLASH) ? countdown - 4'd1 : 4'(FLASH_CYCLES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) countdown <= 4'd0;
    else       countdown <= countdown_n;
  end
`else
  assign countdown = 4'd0;
`endif

endmodule

// File: tb/tb_ped_signal_controller.sv
module tb_ped_signal_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       red = 1'b0, yellow = 1'b0, green = 1'b1, ped_button = 1'b0;
  logic       walk, dont_walk, ped_wait, fault;
  logic [3:0] countdown;

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  // expected entry: {step id[15:0], walk, dont_walk, ped_wait, countdown[3:0], fault}
  logic [23:0] exp_q[$];

  ped_signal_controller #(.WALK_CYCLES(8), .FLASH_CYCLES(6)) dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .ped_button(ped_button), .walk(walk), .dont_walk(dont_walk),
    .ped_wait(ped_wait), .countdown(countdown), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pack_out(logic w, logic dw, logic p, logic [3:0] cd, logic f);
    return {w, dw, p, cd, f};
  endfunction

  function automatic logic [3:0] cd_exp(logic [3:0] cd);
`ifdef PED_COUNTDOWN_EN
    return cd;
`else
    return 4'd0 & cd;
`endif
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic rst, input logic r, input logic y, input logic g,
                      input logic b, input logic w, input logic dw, input logic p,
                      input logic [3:0] cd, input logic f);
    @(negedge clk);
    step_no++;
    reset = rst; red = r; yellow = y; green = g; ped_button = b;
    exp_q.push_back({16'(step_no), pack_out(w, dw, p, cd_exp(cd), f)});
  endtask

  // Monitor: every clock the DUT presents a new output vector.
  initial begin
    logic [23:0] e;
    logic [7:0]  act;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = pack_out(walk, dont_walk, ped_wait, countdown, fault);
        checks++;
        if (act !== e[7:0]) begin
          failures++;
          $display("FAIL step%0d outputs{walk,dont_walk,ped_wait,countdown,fault} got=%b exp=%b",
                   e[23:8], act, e[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] act;
    // reset and first request (served by a red rise)
    step(1,0,0,1,0, 0,1,0,0,0);
    step(0,0,0,1,0, 0,1,0,0,0);
    step(0,0,0,1,1, 0,1,1,0,0);
    step(0,0,0,1,0, 0,1,1,0,0);
    step(0,0,1,0,0, 0,1,1,0,0);
    step(0,1,0,0,0, 1,0,0,0,0);
    for (int i = 0; i < 7; i++) step(0,1,0,0,0, 1,0,0,0,0);
    // flashing don't-walk with countdown
    step(0,1,0,0,0, 0,1,0,6,0);
    step(0,1,0,0,0, 0,0,0,5,0);
    step(0,1,0,0,0, 0,1,0,4,0);
    step(0,1,0,0,0, 0,0,0,3,0);
    step(0,1,0,0,0, 0,1,0,2,0);
    step(0,1,0,0,0, 0,0,0,1,0);
    step(0,1,0,0,0, 0,1,0,0,0);
    // press while red already steady: must wait for next red rise
    step(0,1,0,0,1, 0,1,1,0,0);
    for (int i = 0; i < 3; i++) step(0,1,0,0,0, 0,1,1,0,0);
    step(0,0,0,1,0, 0,1,1,0,0);
    step(0,1,0,0,0, 1,0,0,0,0);
    step(0,1,0,0,0, 1,0,0,0,0);
    step(0,1,0,0,0, 1,0,0,0,0);
    // abort in walk cycle 3
    step(0,0,0,1,0, 0,1,0,0,0);
    step(0,0,0,1,0, 0,1,0,0,0);
    // press in same cycle as red rise, then press during walk
    step(0,1,0,0,1, 1,0,0,0,0);
    step(0,1,0,0,0, 1,0,0,0,0);
    step(0,1,0,0,1, 1,0,1,0,0);
    step(0,1,0,0,0, 1,0,1,0,0);
    // all-dark abort keeps ped_wait, then served on red rise
    step(0,0,0,0,0, 0,1,1,0,0);
    step(0,1,0,0,0, 1,0,0,0,0);
    for (int i = 0; i < 7; i++) step(0,1,0,0,0, 1,0,0,0,0);
    step(0,1,0,0,0, 0,1,0,6,0);
    step(0,1,0,0,1, 0,0,1,5,0);
    // asynchronous reset mid-flash takes effect without a clock edge
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    act = pack_out(walk, dont_walk, ped_wait, countdown, fault);
    checks++;
    if (act !== pack_out(0,1,0,4'd0,0)) begin
      failures++;
      $display("FAIL async_reset outputs got=%b exp=%b", act, pack_out(0,1,0,4'd0,0));
    end
    step(1,1,0,0,0, 0,1,0,0,0);
    step(0,0,0,1,0, 0,1,0,0,0);
    step(0,1,0,0,0, 0,1,0,0,0);
    step(0,1,0,0,0, 0,1,0,0,0);
    // illegal combination latches fault until reset
    step(0,1,0,1,0, 0,1,0,0,1);
    step(0,0,0,1,0, 0,1,0,0,1);
    step(0,1,0,0,1, 0,1,0,0,1);
    step(1,0,0,1,0, 0,1,0,0,0);
    step(0,0,0,1,0, 0,1,0,0,0);
    // fault wins over abort during walk
    step(0,0,0,1,1, 0,1,1,0,0);
    step(0,1,0,0,0, 1,0,0,0,0);
    step(0,0,1,1,0, 0,1,0,0,1);
    step(1,0,0,1,0, 0,1,0,0,0);
    step(0,0,0,1,0, 0,1,0,0,0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
